// File: rtl/xpar_arb_pkg.sv
// xpar_arb shared definitions: widths, master ids, FSM states.
package xpar_arb_pkg;

    localparam int DEF_PADDR_W = 12;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TIMEOUT = 255;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } arb_state_t;

endpackage

// File: rtl/xpar_arb_if.sv
// One requester channel of xpar_arb: req/ack handshake plus data.
interface xpar_arb_if
    import xpar_arb_pkg::*;
#(
    parameter int AW = DEF_PADDR_W,
    parameter int DW = DEF_DATA_W
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic          err;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, err, rdata
    );
endinterface

// File: rtl/xpar_arb_pick2.sv
// Two-way round-robin pick: on a tie the master not served
// last (i_rr holds the last-served id) wins.
module xrr_pick2
    import xpar_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_rr,
    output logic o_valid,
    output logic o_id
);
    assign o_valid = i_req0 | i_req1;

    always_comb begin
        o_id = ARB_M0;
        priority case (1'b1)
            i_req0 && i_req1: o_id = ~i_rr;
            i_req1:           o_id = ARB_M1;
            default:          o_id = ARB_M0;
        endcase
    end
endmodule

// File: rtl/xpar_arb.sv
// xpar_arb: serialises two masters onto the external parallel
// port, running each access as a strobe/ack handshake with timeout.
module xpar_arb
    import xpar_arb_pkg::*;
#(
    parameter int PADDR_W = DEF_PADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    xpar_arb_if.slave          m0,
    xpar_arb_if.slave          m1,
    output logic [PADDR_W-1:0] o_par_addr,
    output logic [DATA_W-1:0]  o_par_out,
    output logic               o_par_re,
    output logic               o_par_we,
    input  logic [DATA_W-1:0]  i_par_in,
    input  logic               i_par_ack
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT != 0);

    arb_state_t         r_state;
    logic               r_own;
    logic               r_rr;
    logic               r_we;
    logic [PADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_re;
    logic               r_wr;
    logic               r_ack0;
    logic               r_ack1;
    logic               r_err0;
    logic               r_err1;
    logic [DATA_W-1:0]  r_rd0;
    logic [DATA_W-1:0]  r_rd1;

    logic               w_gnt;
    logic               w_id;
    logic               w_we;
    logic [PADDR_W-1:0] w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_tmo;
    logic               w_fin;
    logic               w_o0;

    xrr_pick2 u_pick (
        .i_req0  (m0.req),
        .i_req1  (m1.req),
        .i_rr    (r_rr),
        .o_valid (w_gnt),
        .o_id    (w_id)
    );

    assign w_we    = (w_id == ARB_M1) ? m1.we    : m0.we;
    assign w_addr  = (w_id == ARB_M1) ? m1.addr  : m0.addr;
    assign w_wdata = (w_id == ARB_M1) ? m1.wdata : m0.wdata;

    // Slave ack takes priority over an expiring counter.
    assign w_tmo = TMO_EN && !i_par_ack && (r_cnt == CNT_LAST);
    assign w_fin = i_par_ack || w_tmo;
    assign w_o0  = (r_own == ARB_M0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_own   <= ARB_M0;
            r_rr    <= ARB_M1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_re    <= 1'b0;
            r_wr    <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            r_rd0   <= '0;
            r_rd1   <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_gnt) begin
                        r_own   <= w_id;
                        r_we    <= w_we;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_cnt   <= '0;
                        r_re    <= ~w_we;
                        r_wr    <= w_we;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (w_fin) begin
                        r_re    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_ack0  <= w_o0;
                        r_ack1  <= ~w_o0;
                        r_err0  <= w_o0 && !i_par_ack;
                        r_err1  <= !w_o0 && !i_par_ack;
                        r_state <= ST_DONE;
                        if (i_par_ack && !r_we) begin
                            if (w_o0) r_rd0 <= i_par_in;
                            else      r_rd1 <= i_par_in;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_rr    <= r_own;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_par_addr = r_addr;
    assign o_par_out  = r_wdata;
    assign o_par_re   = r_re;
    assign o_par_we   = r_wr;

    assign m0.ack   = r_ack0;
    assign m0.err   = r_err0;
    assign m0.rdata = r_rd0;
    assign m1.ack   = r_ack1;
    assign m1.err   = r_err1;
    assign m1.rdata = r_rd1;
endmodule

// File: tb/tb_xpar_arb.sv
// Directed bench for xpar_arb: per-cycle vector table plus
// hand-written multi-cycle sequences (alternation, reset, timeout).
module tb_xpar_arb;
    import xpar_arb_pkg::*;

    localparam int AW = DEF_PADDR_W;
    localparam int DW = DEF_DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] par_in, tpar_in;
    logic          par_ack, tpar_ack;
    logic [AW-1:0] par_addr, tpar_addr;
    logic [DW-1:0] par_out, tpar_out;
    logic          par_re, par_we, tpar_re, tpar_we;

    xpar_arb_if a0 ();
    xpar_arb_if a1 ();
    xpar_arb_if b0 ();
    xpar_arb_if b1 ();

    xpar_arb #(.TIMEOUT(255)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .m0         (a0),
        .m1         (a1),
        .o_par_addr (par_addr),
        .o_par_out  (par_out),
        .o_par_re   (par_re),
        .o_par_we   (par_we),
        .i_par_in   (par_in),
        .i_par_ack  (par_ack)
    );

    xpar_arb #(.TIMEOUT(4)) dut_t (
        .i_clk      (clk),
        .i_rst      (rst),
        .m0         (b0),
        .m1         (b1),
        .o_par_addr (tpar_addr),
        .o_par_out  (tpar_out),
        .o_par_re   (tpar_re),
        .o_par_we   (tpar_we),
        .i_par_in   (tpar_in),
        .i_par_ack  (tpar_ack)
    );

    typedef struct {
        logic          r0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          pk;
        logic [DW-1:0] pi;
        logic          ere, ewe;
        logic [AW-1:0] ead;
        logic [DW-1:0] eout;
        logic          ea0, ee0, ea1, ee1;
        logic [DW-1:0] erd0, erd1;
    } vec_t;

    vec_t vt[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(
        logic r0, logic w0, logic [AW-1:0] a0_, logic [DW-1:0] d0_,
        logic r1, logic w1, logic [AW-1:0] a1_, logic [DW-1:0] d1_,
        logic pk, logic [DW-1:0] pi,
        logic ere, logic ewe, logic [AW-1:0] ead, logic [DW-1:0] eout,
        logic ea0, logic ee0, logic ea1, logic ee1,
        logic [DW-1:0] erd0, logic [DW-1:0] erd1);
        vec_t v;
        v.r0 = r0;   v.w0 = w0;   v.a0 = a0_;  v.d0 = d0_;
        v.r1 = r1;   v.w1 = w1;   v.a1 = a1_;  v.d1 = d1_;
        v.pk = pk;   v.pi = pi;
        v.ere = ere; v.ewe = ewe; v.ead = ead; v.eout = eout;
        v.ea0 = ea0; v.ee0 = ee0; v.ea1 = ea1; v.ee1 = ee1;
        v.erd0 = erd0; v.erd1 = erd1;
        return v;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        a0.req = v.r0; a0.we = v.w0; a0.addr = v.a0; a0.wdata = v.d0;
        a1.req = v.r1; a1.we = v.w1; a1.addr = v.a1; a1.wdata = v.d1;
        par_ack = v.pk;
        par_in  = v.pi;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, acks, res;
        logic [65:0] act, exp;

        a0.req = 0; a0.we = 0; a0.addr = '0; a0.wdata = '0;
        a1.req = 0; a1.we = 0; a1.addr = '0; a1.wdata = '0;
        b0.req = 0; b0.we = 0; b0.addr = '0; b0.wdata = '0;
        b1.req = 0; b1.we = 0; b1.addr = '0; b1.wdata = '0;
        par_ack = 0; par_in = '0; tpar_ack = 0; tpar_in = '0;

        // contention after reset: m0 write first, then m1 read
        vt.push_back(mk(0,0,'h000,'h0000, 0,0,'h000,'h0000, 0,'h0000,
                        0,0,'h000,'h0000, 0,0,0,0, 'h0000,'h0000));
        vt.push_back(mk(1,1,'h100,'h1111, 1,0,'h200,'h2222, 0,'h0000,
                        0,0,'h000,'h0000, 0,0,0,0, 'h0000,'h0000));
        vt.push_back(mk(1,1,'h100,'h1111, 1,0,'h200,'h2222, 1,'hBEEF,
                        0,1,'h100,'h1111, 0,0,0,0, 'h0000,'h0000));
        vt.push_back(mk(1,1,'h100,'h1111, 1,0,'h200,'h2222, 0,'h0000,
                        0,0,'h100,'h1111, 1,0,0,0, 'h0000,'h0000));
        vt.push_back(mk(0,1,'h100,'h1111, 1,0,'h200,'h2222, 0,'h0000,
                        0,0,'h100,'h1111, 0,0,0,0, 'h0000,'h0000));
        vt.push_back(mk(0,0,'h000,'h0000, 1,0,'h200,'h2222, 1,'hBEEF,
                        1,0,'h200,'h2222, 0,0,0,0, 'h0000,'h0000));
        vt.push_back(mk(0,0,'h000,'h0000, 1,0,'h200,'h2222, 0,'h0000,
                        0,0,'h200,'h2222, 0,0,1,0, 'h0000,'hBEEF));
        vt.push_back(mk(0,0,'h000,'h0000, 0,0,'h000,'h0000, 0,'h0000,
                        0,0,'h200,'h2222, 0,0,0,0, 'h0000,'hBEEF));
        // single read of 0x012
        vt.push_back(mk(1,0,'h012,'h0000, 0,0,'h000,'h0000, 0,'h0000,
                        0,0,'h200,'h2222, 0,0,0,0, 'h0000,'hBEEF));
        vt.push_back(mk(1,0,'h012,'h0000, 0,0,'h000,'h0000, 1,'hCAFE,
                        1,0,'h012,'h0000, 0,0,0,0, 'h0000,'hBEEF));
        vt.push_back(mk(1,0,'h012,'h0000, 0,0,'h000,'h0000, 0,'h0000,
                        0,0,'h012,'h0000, 1,0,0,0, 'hCAFE,'hBEEF));
        vt.push_back(mk(0,0,'h000,'h0000, 0,0,'h000,'h0000, 0,'h0000,
                        0,0,'h012,'h0000, 0,0,0,0, 'hCAFE,'hBEEF));
        // m1 write stalled 5 cycles; fields changed after grant
        vt.push_back(mk(0,0,'h000,'h0000, 1,1,'h7F0,'h55AA, 0,'h0000,
                        0,0,'h012,'h0000, 0,0,0,0, 'hCAFE,'hBEEF));
        vt.push_back(mk(0,0,'h000,'h0000, 1,1,'h7F0,'h55AA, 0,'h0000,
                        0,1,'h7F0,'h55AA, 0,0,0,0, 'hCAFE,'hBEEF));
        vt.push_back(mk(0,0,'h000,'h0000, 1,0,'h7F1,'hFFFF, 0,'h0000,
                        0,1,'h7F0,'h55AA, 0,0,0,0, 'hCAFE,'hBEEF));
        vt.push_back(mk(0,0,'h000,'h0000, 1,0,'h7F1,'hFFFF, 0,'h0000,
                        0,1,'h7F0,'h55AA, 0,0,0,0, 'hCAFE,'hBEEF));
        vt.push_back(mk(0,0,'h000,'h0000, 1,0,'h7F1,'hFFFF, 0,'h0000,
                        0,1,'h7F0,'h55AA, 0,0,0,0, 'hCAFE,'hBEEF));
        vt.push_back(mk(0,0,'h000,'h0000, 1,0,'h7F1,'hFFFF, 1,'h1357,
                        0,1,'h7F0,'h55AA, 0,0,0,0, 'hCAFE,'hBEEF));
        vt.push_back(mk(0,0,'h000,'h0000, 1,0,'h7F1,'hFFFF, 0,'h0000,
                        0,0,'h7F0,'h55AA, 0,0,1,0, 'hCAFE,'hBEEF));
        // stray par_ack while idle must be ignored
        vt.push_back(mk(0,0,'h000,'h0000, 0,0,'h000,'h0000, 1,'h9999,
                        0,0,'h7F0,'h55AA, 0,0,0,0, 'hCAFE,'hBEEF));
        vt.push_back(mk(0,0,'h000,'h0000, 0,0,'h000,'h0000, 1,'h9999,
                        0,0,'h7F0,'h55AA, 0,0,0,0, 'hCAFE,'hBEEF));

        repeat (3) @(negedge clk);
        rst = 0;
        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i]);
            act = {par_re, par_we, par_addr, par_out,
                   a0.ack, a0.err, a1.ack, a1.err, a0.rdata, a1.rdata};
            exp = {vt[i].ere, vt[i].ewe, vt[i].ead, vt[i].eout,
                   vt[i].ea0, vt[i].ee0, vt[i].ea1, vt[i].ee1,
                   vt[i].erd0, vt[i].erd1};
            chk($sformatf("vec%0d", i), act, exp);
            @(negedge clk);
        end
        par_ack = 0;

        // strict alternation with both masters always requesting
        rst = 1;
        @(negedge clk);
        rst = 0;
        a0.req = 1; a0.we = 0; a0.addr = 'h0A0;
        a1.req = 1; a1.we = 0; a1.addr = 'h0B0;
        par_ack = 1; par_in = '0;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (!(a0.ack | a1.ack) && n < 6) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("alt%0d_ack", k), a0.ack | a1.ack, 1);
            chk($sformatf("alt%0d_who", k), {a1.ack, a0.ack},
                k[0] ? 2'b10 : 2'b01);
            if (k == 7) begin
                a0.req = 0;
                a1.req = 0;
            end
            @(negedge clk);
        end
        par_ack = 0;
        @(negedge clk);

        // reset in the middle of an access
        a0.req = 1; a0.we = 0; a0.addr = 'h321;
        @(negedge clk);
        chk("rst_pre_re", par_re, 1);
        rst = 1;
        @(negedge clk);
        chk("rst_outs", {par_re, par_we, a0.ack, a0.err, a1.ack,
                         a1.err, a0.rdata, a1.rdata}, '0);
        rst = 0;
        par_ack = 1; par_in = 'h7777;
        @(negedge clk);
        chk("rst_again", {par_re, a0.ack}, 2'b10);
        @(negedge clk);
        chk("rst_fresh", {a0.ack, a0.err, a0.rdata}, {2'b10, 16'h7777});
        a0.req = 0; par_ack = 0;
        @(negedge clk);

        // m1 withdraws req and moves addr while the access runs
        a1.req = 1; a1.we = 0; a1.addr = 'h333; a1.wdata = '0;
        @(negedge clk);
        chk("wd_addr0", {par_re, par_addr}, {1'b1, 12'h333});
        a1.req = 0; a1.addr = 'h444;
        @(negedge clk);
        chk("wd_addr1", {par_re, par_addr}, {1'b1, 12'h333});
        par_ack = 1; par_in = 'h4242;
        @(negedge clk);
        par_ack = 0;
        acks = int'(a1.ack);
        res = 0;
        repeat (4) begin
            @(negedge clk);
            acks += int'(a1.ack);
            res  |= int'(par_re);
        end
        chk("wd_acks", acks, 1);
        chk("wd_nore", res, 0);
        chk("wd_rdata", a1.rdata, 'h4242);

        // timeout instance: seed m0 rdata, then let the slave die
        b0.req = 1; b0.we = 0; b0.addr = 'h050;
        tpar_ack = 1; tpar_in = 'h1234;
        n = 0;
        while (!b0.ack && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("to_seed", {b0.ack, b0.rdata}, {1'b1, 16'h1234});
        b0.req = 0; tpar_ack = 0;
        @(negedge clk);
        b0.req = 1; b0.addr = 'h060;
        n = 0; cnt = 0;
        while (!b0.ack && n < 20) begin
            @(negedge clk);
            n++;
            if (tpar_re) cnt++;
        end
        chk("to_ackerr", {b0.ack, b0.err}, 2'b11);
        chk("to_strobes", cnt, 4);
        chk("to_rdata", b0.rdata, 'h1234);
        b0.req = 0;
        @(negedge clk);
        chk("to_pulse", {b0.ack, b0.err, tpar_re}, 3'b000);
        b1.req = 1; b1.we = 0; b1.addr = 'h070;
        tpar_ack = 1; tpar_in = 'h5678;
        n = 0;
        while (!b1.ack && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("to_next", {b1.ack, b1.err, b1.rdata}, {2'b10, 16'h5678});
        b1.req = 0; tpar_ack = 0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/xpar_arb.md
# xpar_arb

Two-master arbiter and access sequencer for the external parallel interface (par_addr/par_in/par_out/par_re/par_we) of the picoversat top level. Requesters are the picoversat data bus (through an ack-aware bridge) and a second bus master such as a DMA or debug engine. The block serialises their accesses with round-robin fairness and runs each access as a strobe/acknowledge handshake with the external slave. A bounded timeout guarantees that a dead slave cannot hang either master.

## Interface
- PADDR_W, `ADDR_W-1, external word address width
- DATA_W, `DATA_W, data width
- TIMEOUT, 255, maximum ACCESS cycles without par_ack; 0 disables the timeout
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  access request; held high until the matching ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  PADDR_W  word address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  high together with ack when the access timed out
- m0_rdata / m1_rdata  out  DATA_W  read data; valid in the ack cycle and held until the next completion for that master
- par_addr  out  PADDR_W  external address
- par_out  out  DATA_W  external write data
- par_re / par_we  out  1  external read/write strobe
- par_in  in  DATA_W  external read data
- par_ack  in  1  slave completion, sampled at each ACCESS-cycle edge

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset enters IDLE.
- IDLE
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the master that was not served last. The rr pointer holds the last-served master and resets to 1, so m0 wins the first tie.
  - On grant, register we/addr/wdata and the owner id, clear the timeout counter, and go to ACCESS.
- ACCESS
  - par_re = ~we_q or par_we = we_q is driven from registered state.
  - par_addr/par_out come from the latched values and stay stable for the whole access.
  - If par_ack = 1, capture par_in into the owner's rdata (reads only) and go to DONE with err = 0.
  - Otherwise, when TIMEOUT ≠ 0 and the counter reaches TIMEOUT-1, go to DONE with err = 1. Owner rdata is unchanged.
  - Otherwise, increment the counter.
- DONE
  - The owner's ack is pulsed for exactly one cycle, plus err if the access timed out.
  - Strobes are low.
  - rr pointer ← owner; next state is IDLE.
- Requester rules:
  - Dropping req during ACCESS does not abort the access. It completes and is acked.
  - The latched fields ignore later changes on m*_addr/we/wdata.
- Reset mid-access: on the reset edge, all strobes, acks and errs go low, the FSM goes to IDLE, and the in-flight access is abandoned without an ack.
- Reset values: par_re = par_we = 0, par_addr = 0, par_out = 0, m*_ack = m*_err = 0, m*_rdata = 0.

## Timing
- Cycle n: req seen in IDLE. Cycle n+1: strobes high. If par_ack = 1 in n+1, ack appears in n+2.
- Minimum req→ack latency is 2 cycles. Minimum back-to-back period is 3 cycles per access (IDLE, ACCESS, DONE).
- Slave stall of k cycles (par_ack first high in the k-th ACCESS cycle, k ≥ 1) gives latency 1+k cycles.
- Timeout: exactly TIMEOUT ACCESS cycles of strobe, then DONE with err.
- A requester drops req on the edge after it samples ack. The following IDLE cycle therefore sees it low, and no duplicate access is issued.
- par_ack outside ACCESS is ignored.

## Structure
- FSM state encodings, the TIMEOUT default and the ARB_M0/ARB_M1 ids go in xdefs.vh, alongside `ADDR_W/`DATA_W.
- One natural sub-module: xrr_pick2.
  - Purely combinational.
  - Inputs: two reqs and the rr pointer. Outputs: grant valid and winner id.
- FSM, latches and timeout counter stay in xpar_arb. Output strobes are registered.

## Test plan
- Single read: m0 reads 0x012; slave returns 0xCAFE with par_ack in the first ACCESS cycle → par_re high for exactly 1 cycle, m0_ack 2 cycles after req, m0_rdata = 0xCAFE, m0_err = 0.
- Contention: m0 and m1 request in the same cycle after reset → m0 served first, then m1. Repeated simultaneous requests alternate strictly m0, m1, m0, m1 over 8 accesses.
- Stalled write: m1 writes 0x55AA to 0x7F0 and the slave delays par_ack by 5 cycles → par_we high for 5 cycles, with par_addr/par_out stable throughout. Then m1_ack.
- Timeout: TIMEOUT = 4 and par_ack is never asserted → strobe held for exactly 4 cycles, then m0_ack = m0_err = 1 for one cycle and m0_rdata unchanged. The next m1 request proceeds normally.
- Reset mid-access: assert rst during ACCESS → next cycle all strobes/acks low and FSM in IDLE. A fresh m0 request after reset completes normally.
- Request withdrawal: m1 drops req in the ACCESS cycle → access still completes and m1_ack pulses once. The addr change after grant is not reflected on par_addr.
